// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: requester ownership, return-path tags
// and the CPU request state machine encoding.
package vram_pkg;

  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 32;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  // valid=0 marks a slot that returns nothing (idle cycle or CPU write)
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_ISSUE = 2'd1,
    C_WAIT  = 2'd2,
    C_ACK   = 2'd3
  } cpu_state_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_VID};

  function automatic tag_t make_tag(input logic valid, input owner_t owner);
    tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters and the VRAM BRAM.
// Handshakes: vid_req is a one-word-per-cycle strobe answered by a vid_valid
// pulse; cpu_req is a level held with stable fields until the one-cycle
// cpu_ack pulse; ram_rdata returns RD_LAT cycles after ram_en.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  localparam int BE_W = DATA_W / 8;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ram_en;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr,
    output vid_valid, vid_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_ack, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_valid, vid_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_ack, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/vram_tag_pipe.sv
// Shift register of return-path tags that travels alongside each RAM access
// so the tail lines up with the corresponding ram_rdata word.
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between the video fetcher (strict priority,
// one read per cycle) and the CPU bridge (served in cycles video leaves idle).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic          Clk,
  input  logic          reset_ah,
  vram_arbiter_if.slave bus,
  output logic [15:0]   cpu_wait_max,
  output cpu_state_t    cpu_state_o
);

  localparam int BE_W      = DATA_W / 8;
  localparam int TAG_DEPTH = RD_LAT + 1;

  cpu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]       wait_max_q, wait_max_d;

  logic              ram_en_q, ram_en_d;
  logic [BE_W-1:0]   ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

  logic grant_vid, grant_cpu;
  tag_t tag_in, tag_tail;

  // Video always wins; there is deliberately no anti-starvation override.
  assign grant_vid = bus.vid_req;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    cpu_rdata_d = cpu_rdata_q;
    wait_cnt_d  = wait_cnt_q;
    wait_max_d  = (wait_cnt_q > wait_max_q) ? wait_cnt_q : wait_max_q;
    grant_cpu   = 1'b0;

    unique case (state_q)
      C_IDLE: begin
        if (bus.cpu_req) begin
          req_addr_d  = bus.cpu_addr;
          req_we_d    = bus.cpu_we;
          req_wdata_d = bus.cpu_wdata;
          req_be_d    = bus.cpu_be;
          wait_cnt_d  = '0;
          state_d     = C_ISSUE;
        end
      end
      C_ISSUE: begin
        if (!bus.vid_req) begin
          grant_cpu  = 1'b1;
          wait_cnt_d = '0;
          state_d    = req_we_q ? C_ACK : C_WAIT;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      C_WAIT: begin
        if (tag_tail.valid && tag_tail.owner == OWN_CPU) begin
          cpu_rdata_d = bus.ram_rdata;
          state_d     = C_ACK;
        end
      end
      C_ACK: begin
        state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    ram_en_d    = grant_vid | grant_cpu;
    ram_we_d    = '0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if (grant_vid) begin
      ram_addr_d = bus.vid_addr;
    end else if (grant_cpu) begin
      ram_addr_d  = req_addr_q;
      ram_wdata_d = req_wdata_q;
      if (req_we_q) begin
        ram_we_d = req_be_q;
      end
    end
    // Writes produce no read data, so their tag stays invalid.
    tag_in = make_tag(grant_vid | (grant_cpu & ~req_we_q),
                      grant_vid ? OWN_VID : OWN_CPU);

    vid_valid_d = tag_tail.valid && (tag_tail.owner == OWN_VID);
    vid_rdata_d = vid_valid_d ? bus.ram_rdata : vid_rdata_q;
  end

  vram_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk_i (Clk),
    .clr_i (reset_ah),
    .tag_i (tag_in),
    .tag_o (tag_tail)
  );

  always_ff @(posedge Clk) begin
    if (reset_ah) begin
      state_q     <= C_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      cpu_rdata_q <= '0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      cpu_rdata_q <= cpu_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_max_q  <= wait_max_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      vid_valid_q <= vid_valid_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.cpu_ack   = (state_q == C_ACK);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign cpu_wait_max  = wait_max_q;
  assign cpu_state_o   = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter: a per-cycle video schedule,
// a blocking CPU driver, a BRAM model and a reference memory feeding a scoreboard.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;
  localparam int MAXC   = 4000;
  localparam int MEM_N  = 1 << ADDR_W;

  logic        clk;
  logic        rst;
  logic [15:0] wait_max;
  cpu_state_t  state_dbg;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk          (clk),
    .reset_ah     (rst),
    .bus          (bus),
    .cpu_wait_max (wait_max),
    .cpu_state_o  (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wmax   = 0;

  bit                vid_on [MAXC];
  logic [ADDR_W-1:0] vid_ad [MAXC];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] rd_sr [RD_LAT];

  int                vid_cyc_q[$];
  logic [DATA_W-1:0] vid_exp_q[$];
  int                cpu_cyc_q[$];
  logic [DATA_W-1:0] cpu_exp_q[$];
  bit                cpu_rd_q[$];

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i < 10) return 32'hA000 + 32'(i);
    return 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  function automatic bit vid_at(input int c);
    if (c < 0 || c >= MAXC) return 1'b0;
    return vid_on[c];
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [3:0] be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sched(input int c, input logic [ADDR_W-1:0] a);
    if (c >= 0 && c < MAXC) begin
      vid_on[c] = 1'b1;
      vid_ad[c] = a;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
    chk({tag, "_vid_rdata"}, bus.vid_rdata, 32'd0);
    chk({tag, "_cpu_ack"},   32'(bus.cpu_ack), 32'd0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
    chk({tag, "_ram_en"},    32'(bus.ram_en), 32'd0);
    chk({tag, "_ram_we"},    32'(bus.ram_we), 32'd0);
    chk({tag, "_ram_addr"},  32'(bus.ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
    chk({tag, "_wait_max"},  32'(wait_max), 32'd0);
    chk({tag, "_state"},     32'(state_dbg), 32'(C_IDLE));
  endtask

  // ---------------- BRAM model ----------------
  initial begin
    for (int i = 0; i < MEM_N; i++) mem[i] = init_word(i);
    for (int s = 0; s < RD_LAT; s++) rd_sr[s] = '0;
    forever begin
      @(posedge clk);
      for (int s = RD_LAT - 1; s > 0; s--) rd_sr[s] <= rd_sr[s-1];
      if (bus.ram_en === 1'b1) begin
        rd_sr[0] <= mem[bus.ram_addr];
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  assign bus.ram_rdata = rd_sr[RD_LAT-1];

  // ---------------- video driver (follows the schedule) ----------------
  initial begin
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (vid_at(cyc)) begin
        bus.vid_req  = 1'b1;
        bus.vid_addr = vid_ad[cyc];
        vid_cyc_q.push_back(cyc + 2 + RD_LAT);
        vid_exp_q.push_back(ref_mem[vid_ad[cyc]]);
      end else begin
        bus.vid_req  = 1'b0;
        bus.vid_addr = '0;
      end
    end
  end

  // ---------------- CPU driver ----------------
  // The CPU slot is the first video-free cycle after the request is seen.
  task automatic cpu_txn(input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [3:0] be,
                         output logic [DATA_W-1:0] rdata);
    int n, f;
    bit got, applied;
    n = cyc;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
    f = n + 1;
    while (vid_at(f)) f++;
    if (f - n - 1 > wmax) wmax = f - n - 1;
    cpu_cyc_q.push_back(we ? f + 1 : f + 2 + RD_LAT);
    cpu_rd_q.push_back(!we);
    cpu_exp_q.push_back(we ? '0 : ref_mem[addr]);
    got = 1'b0;
    applied = 1'b0;
    rdata = '0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (we && !applied && cyc >= f) begin
        ref_mem[addr] = merge(ref_mem[addr], wdata, be);
        applied = 1'b1;
      end
      if (bus.cpu_ack === 1'b1) begin
        got = 1'b1;
        rdata = bus.cpu_rdata;
      end
    end
    chk("cpu_ack_seen", 32'(got), 32'd1);
    next_cycle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be    = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    int ec;
    logic [DATA_W-1:0] ed;
    bit rd;
    forever begin
      @(negedge clk);
      if (bus.vid_valid === 1'b1) begin
        if (vid_exp_q.size() == 0) begin
          chk("vid_unexpected_valid", 32'd1, 32'd0);
        end else begin
          ec = vid_cyc_q.pop_front();
          ed = vid_exp_q.pop_front();
          chk("vid_cycle", 32'(cyc), 32'(ec));
          chk("vid_data", bus.vid_rdata, ed);
        end
      end
      if (bus.cpu_ack === 1'b1) begin
        if (cpu_exp_q.size() == 0) begin
          chk("cpu_unexpected_ack", 32'd1, 32'd0);
        end else begin
          ec = cpu_cyc_q.pop_front();
          ed = cpu_exp_q.pop_front();
          rd = cpu_rd_q.pop_front();
          chk("cpu_ack_cycle", 32'(cyc), 32'(ec));
          if (rd) chk("cpu_rdata", bus.cpu_rdata, ed);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] rd;
    int base, end_c;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be    = '0;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    next_cycle();

    // Video stream of 10 back-to-back reads
    base = cyc;
    for (int k = 0; k < 10; k++) sched(base + 1 + k, ADDR_W'(k));
    repeat (16) next_cycle();

    // CPU write then read, idle video
    cpu_txn(1'b1, 'h12, 32'hDEAD_BEEF, 4'b1111, rd);
    cpu_txn(1'b0, 'h12, '0, 4'b0000, rd);
    chk("wr_rd_readback", rd, 32'hDEAD_BEEF);

    // Partial byte-enable write
    cpu_txn(1'b1, 'h12, 32'h0000_00FF, 4'b0001, rd);
    cpu_txn(1'b0, 'h12, '0, 4'b0000, rd);
    chk("be_readback", rd, 32'hDEAD_BEFF);

    // Contention: 20 cycles of video while a CPU read is pending
    base = cyc;
    for (int k = 1; k <= 20; k++) sched(base + k, ADDR_W'($urandom_range(0, 63)));
    cpu_txn(1'b0, 'h05, '0, 4'b0000, rd);
    chk("contention_rdata", rd, init_word(5));
    chk("contention_wait_max", 32'(wait_max), 32'd20);

    // Same-address collision: video reads of 0x12 before and after the write
    base = cyc;
    sched(base + 1, 'h12);
    sched(base + 2, 'h12);
    cpu_txn(1'b1, 'h12, 32'h5555_AAAA, 4'b1111, rd);
    base = cyc;
    sched(base + 1, 'h12);
    repeat (6) next_cycle();

    // Reset in the middle of a CPU read
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 'h30;
    next_cycle();
    next_cycle();
    chk("midread_ram_en", 32'(bus.ram_en), 32'd1);
    next_cycle();
    rst = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    next_cycle();
    check_reset_outputs("midread");
    next_cycle();
    rst  = 1'b0;
    wmax = 0;
    next_cycle();
    cpu_txn(1'b0, 'h30, '0, 4'b0000, rd);
    chk("post_reset_read", rd, init_word(48));

    // Random traffic: video over 0..63, CPU writes over 64..127
    base = cyc;
    for (int c = base + 1; c <= base + 600; c++)
      if ($urandom_range(0, 99) < 55) sched(c, ADDR_W'($urandom_range(0, 63)));
    for (int c = base + 200; c <= base + 230; c++) sched(c, ADDR_W'($urandom_range(0, 63)));
    end_c = base + 610;
    while (cyc < base + 560) begin
      bit we;
      logic [ADDR_W-1:0] a;
      repeat ($urandom_range(0, 3)) next_cycle();
      we = 1'($urandom_range(0, 1));
      if (!we && $urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, 63));
      else a = ADDR_W'(64 + $urandom_range(0, 63));
      cpu_txn(we, a, $urandom(), 4'($urandom_range(0, 15)), rd);
    end

    for (int k = 0; k < 300 && (cyc <= end_c || vid_exp_q.size() != 0 || cpu_exp_q.size() != 0); k++)
      next_cycle();
    chk("vid_queue_drained", 32'(vid_exp_q.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'd0);
    chk("final_wait_max", 32'(wait_max), 32'(wmax));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
